// File: rtl/uart_wb_master_pkg.sv
// Shared constants for the UART-driven Wishbone initiator: command/response
// bytes, FSM state encoding and the response-load descriptor.
package uart_wb_master_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_BADCMD  = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h45;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  len;
    } resp_load_t;

    function automatic resp_load_t resp_byte(input logic [7:0] b);
        resp_load_t r;
        r.data = {24'h0, b};
        r.len  = 3'd1;
        return r;
    endfunction

endpackage

// File: rtl/uart_wb_master_resp.sv
// Response shifter: holds up to four bytes and presents them LSB first on a
// valid/ready byte stream.
module uart_wb_master_resp (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_len,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accept
);

    logic [31:0] shift;
    logic [2:0]  left;
    logic        accept;

    assign tx_valid    = (left != 3'd0);
    assign tx_data     = shift[7:0];
    assign accept      = tx_valid && tx_ready;
    assign last_accept = accept && (left == 3'd1);

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift <= '0;
            left  <= '0;
        end else if (load) begin
            shift <= load_data;
            left  <= load_len;
        end else if (accept) begin
            shift <= {8'h00, shift[31:8]};
            left  <= left - 3'd1;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// UART byte stream to Wishbone initiator. Define UART_WB_MASTER_TIMEOUT_EN to
// abort a bus cycle with an 'E' response after timeout_cycles without ack.
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int sel_width      = data_width / 8,
    parameter int timeout_cycles = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [addr_width-1:0] wb_adr,
    output logic [data_width-1:0] wb_datwr,
    input  logic [data_width-1:0] wb_datrd,
    output logic                  wb_we,
    output logic                  wb_stb,
    output logic                  wb_cyc,
    output logic [sel_width-1:0]  wb_sel,
    input  logic                  wb_ack,
    output logic                  busy,
    output logic                  rx_overrun
);

    logic [2:0]  state;
    logic [1:0]  cnt;
    logic        is_write;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        bus_q;
    logic        we_q;
    logic        tmo_hit;
    logic        last_accept;
    logic        resp_load;
    resp_load_t  resp_val;

    assign wb_adr   = addr_width'(addr_q);
    assign wb_datwr = data_width'(data_q);
    assign wb_cyc   = bus_q;
    assign wb_stb   = bus_q;
    assign wb_we    = we_q;
    assign wb_sel   = {sel_width{bus_q}};
    assign busy     = (state != ST_IDLE);

`ifdef UART_WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(timeout_cycles + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero outside BUS, so it is cleared on every entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state != ST_BUS)
            tmo_cnt <= '0;
        else if (!wb_ack)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == ST_BUS) && !wb_ack && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        resp_load = 1'b0;
        resp_val  = '0;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data != CMD_WRITE && rx_data != CMD_READ) begin
                    resp_load = 1'b1;
                    resp_val  = resp_byte(RSP_BADCMD);
                end
            end
            ST_BUS: begin
                if (wb_ack) begin
                    resp_load = 1'b1;
                    if (is_write) begin
                        resp_val = resp_byte(RSP_OK);
                    end else begin
                        resp_val.data = 32'(wb_datrd);
                        resp_val.len  = 3'd4;
                    end
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    resp_val  = resp_byte(RSP_TIMEOUT);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            bus_q      <= 1'b0;
            we_q       <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_valid && (state == ST_BUS || state == ST_RESP);
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                            is_write <= (rx_data == CMD_WRITE);
                            cnt      <= '0;
                            state    <= ST_ADDR;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_q[{cnt, 3'b000} +: 8] <= rx_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_write) begin
                                state <= ST_DATA;
                            end else begin
                                state <= ST_BUS;
                                bus_q <= 1'b1;
                                we_q  <= 1'b0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        data_q[{cnt, 3'b000} +: 8] <= rx_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= ST_BUS;
                            bus_q <= 1'b1;
                            we_q  <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (wb_ack || tmo_hit) begin
                        bus_q <= 1'b0;
                        we_q  <= 1'b0;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (last_accept)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_wb_master_resp u_resp (
        .clock       (clock),
        .reset       (reset),
        .load        (resp_load),
        .load_data   (resp_val.data),
        .load_len    (resp_val.len),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .last_accept (last_accept)
    );

endmodule

// File: tb/tb_uart_wb_master.sv
// Scoreboard bench for uart_wb_master: stimulus pushes expected bus cycles and
// tx bytes into queues, negedge monitors pop and compare.
module tb_uart_wb_master;

`ifdef UART_WB_MASTER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clock;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr;
    logic [31:0] wb_datwr;
    logic [31:0] wb_datrd;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        busy;
    logic        rx_overrun;

    uart_wb_master #(
        .addr_width     (32),
        .data_width     (32),
        .sel_width      (4),
        .timeout_cycles (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .wb_adr     (wb_adr),
        .wb_datwr   (wb_datwr),
        .wb_datrd   (wb_datrd),
        .wb_we      (wb_we),
        .wb_stb     (wb_stb),
        .wb_cyc     (wb_cyc),
        .wb_sel     (wb_sel),
        .wb_ack     (wb_ack),
        .busy       (busy),
        .rx_overrun (rx_overrun)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;

    // Slave and tx-sink controls
    bit          slave_en    = 1;
    int          ack_delay   = 0;
    logic [31:0] slave_rdata = '0;
    bit          bp_mode     = 0;
    int          bp_cnt      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] actual);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing", name, actual);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && tx_q.size() == 0) break;
            tick();
        end
        check(name, {busy, 31'(tx_q.size())}, 64'd0);
    endtask

    // Wishbone slave: ack after ack_delay wait cycles, one-cycle ack
    initial begin
        int wait_cnt = 0;
        wb_ack   = 1'b0;
        wb_datrd = '0;
        forever begin
            tick();
            if (wb_ack) begin
                wb_ack = 1'b0;
            end else if (wb_cyc && wb_stb && slave_en) begin
                if (wait_cnt >= ack_delay) begin
                    wb_ack   = 1'b1;
                    wb_datrd = slave_rdata;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Tx sink: always ready, or ready one cycle in six under backpressure
    initial begin
        tx_ready = 1'b1;
        forever begin
            tick();
            if (bp_mode) begin
                bp_cnt   = (bp_cnt + 1) % 6;
                tx_ready = (bp_cnt == 0);
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Bus monitor: compares the first cycle of every cyc assertion
    initial begin
        bit cyc_prev = 0;
        bus_exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                cyc_prev = 0;
            end else begin
                if (wb_cyc && !cyc_prev) begin
                    if (bus_q.size() == 0) begin
                        fail_now("bus_unexpected_cycle", 64'(wb_adr));
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_adr", 64'(wb_adr), 64'(e.adr));
                        check("bus_we", 64'(wb_we), 64'(e.we));
                        check("bus_sel", 64'(wb_sel), 64'hF);
                        check("bus_stb", 64'(wb_stb), 64'd1);
                        if (e.we) check("bus_datwr", 64'(wb_datwr), 64'(e.dat));
                    end
                end
                cyc_prev = wb_cyc;
            end
        end
    end

    // Tx monitor: pops expected bytes on each accepted transfer, checks hold stability
    initial begin
        bit         hold = 0;
        logic [7:0] hold_data = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("tx_hold_valid", 64'(tx_valid), 64'd1);
                    check("tx_hold_data", 64'(tx_data), 64'(hold_data));
                end
                if (tx_valid && tx_ready) begin
                    if (tx_q.size() == 0) fail_now("tx_unexpected_byte", 64'(tx_data));
                    else check("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
                end
                hold      = tx_valid && !tx_ready;
                hold_data = tx_data;
            end
        end
    end

    always @(negedge clock) if (!reset && rx_overrun) ovr_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ovr;
        int n;
        reset    = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        #1;
        check("rst_cyc", 64'(wb_cyc), 64'd0);
        check("rst_stb", 64'(wb_stb), 64'd0);
        check("rst_we", 64'(wb_we), 64'd0);
        check("rst_sel", 64'(wb_sel), 64'd0);
        check("rst_adr", 64'(wb_adr), 64'd0);
        check("rst_tx", {tx_valid, 8'(tx_data)}, 64'd0);
        check("rst_busy_ovr", {busy, rx_overrun}, 64'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Write, ack after 3 wait cycles
        ack_delay = 3;
        bus_q.push_back('{adr: 32'h0000_1000, dat: 32'hDEAD_BEEF, we: 1'b1});
        tx_q.push_back(8'h4B);
        send_frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
        check("cyc_latency_write", 64'(wb_cyc), 64'd1);
        wait_idle("write_done", 200);

        // Read, immediate ack
        ack_delay   = 0;
        slave_rdata = 32'hCAFE_F00D;
        bus_q.push_back('{adr: 32'h0000_1000, dat: 32'h0, we: 1'b0});
        tx_q.push_back(8'h0D); tx_q.push_back(8'hF0);
        tx_q.push_back(8'hFE); tx_q.push_back(8'hCA);
        send_frame(8'h52, 32'h0000_1000, 32'h0);
        check("cyc_latency_read", 64'(wb_cyc), 64'd1);
        wait_idle("read_done", 200);

        // Write with distinct address bytes, zero-wait ack
        bus_q.push_back('{adr: 32'hA5C3_0FF0, dat: 32'h0102_0304, we: 1'b1});
        tx_q.push_back(8'h4B);
        send_frame(8'h57, 32'hA5C3_0FF0, 32'h0102_0304);
        wait_idle("write2_done", 200);

        // Read under tx backpressure
        ack_delay   = 2;
        slave_rdata = 32'h1234_5678;
        bp_cnt      = 0;
        bp_mode     = 1;
        bus_q.push_back('{adr: 32'h0000_2000, dat: 32'h0, we: 1'b0});
        tx_q.push_back(8'h78); tx_q.push_back(8'h56);
        tx_q.push_back(8'h34); tx_q.push_back(8'h12);
        send_frame(8'h52, 32'h0000_2000, 32'h0);
        wait_idle("bp_read_done", 400);
        bp_mode = 0;
        tick();

        // Bad command
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        check("badcmd_busy", 64'(busy), 64'd1);
        wait_idle("badcmd_done", 50);

        // Overrun: a byte arrives while the bus cycle is pending
        base_ovr    = ovr_cnt;
        ack_delay   = 5;
        slave_rdata = 32'h0BAD_F00D;
        bus_q.push_back('{adr: 32'h0000_4000, dat: 32'h0, we: 1'b0});
        tx_q.push_back(8'h0D); tx_q.push_back(8'hF0);
        tx_q.push_back(8'hAD); tx_q.push_back(8'h0B);
        send_frame(8'h52, 32'h0000_4000, 32'h0);
        send_byte(8'h99);
        wait_idle("overrun_done", 200);
        check("overrun_pulses", 64'(ovr_cnt - base_ovr), 64'd1);

        // Reset in the middle of a bus cycle
        slave_en = 0;
        bus_q.push_back('{adr: 32'h0000_3000, dat: 32'h0, we: 1'b0});
        send_frame(8'h52, 32'h0000_3000, 32'h0);
        tick(); tick();
        check("midrst_cyc_before", 64'(wb_cyc), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_cyc_stb", {wb_cyc, wb_stb}, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_tx_idle", 64'(tx_valid), 64'd0);

`ifdef UART_WB_MASTER_TIMEOUT_EN
        // Timeout: no ack, cyc must stay up exactly TMO cycles
        bus_q.push_back('{adr: 32'h0000_5000, dat: 32'h0, we: 1'b0});
        tx_q.push_back(8'h45);
        send_frame(8'h52, 32'h0000_5000, 32'h0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!wb_cyc) break;
            n++;
            tick();
        end
        check("timeout_cyc_len", 64'(n), 64'(TMO));
        wait_idle("timeout_done", 50);
`else
        n = 0;
`endif
        slave_en = 1;
        tick();

        check("bus_queue_empty", 64'(bus_q.size()), 64'd0);
        check("tx_queue_empty", 64'(tx_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Wishbone initiator driven by a UART byte stream; the host-side counterpart of the UART responder peripheral.
- Lets an external host load SRAM and peek/poke peripherals over the serial link, for example for a bootloader or debug access.
- Connects as an extra master port on the crossbar, next to the CPU.
- Sits between a UART rx/tx byte core and the crossbar master inputs.

Parameters:
- addr_width, 32, Wishbone address width.
- data_width, 32, Wishbone data width. Only 32 is supported; the framing below assumes 4 bytes.
- sel_width, data_width/8, byte-select width.
- timeout_cycles, 1024, ack timeout in clocks. Used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  single-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- wb_adr  out  addr_width  bus address
- wb_datwr  out  data_width  write data
- wb_datrd  in  data_width  read data
- wb_we  out  1  write enable
- wb_stb  out  1  strobe
- wb_cyc  out  1  cycle
- wb_sel  out  sel_width  byte selects
- wb_ack  in  1  slave acknowledge
- busy  out  1  high whenever state is not IDLE
- rx_overrun  out  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset (async, active-high): state=IDLE. All wb_* outputs 0, tx_valid=0, tx_data=0, busy=0, rx_overrun=0, byte counter=0.
- Frame format, bytes little-endian:
  - Write: 0x57 'W', addr[7:0]..addr[31:24], data[7:0]..data[31:24].
  - Read: 0x52 'R', addr[7:0]..addr[31:24].
- States:
  - IDLE: on rx_valid, 'W' or 'R' latches the command and goes to ADDR with cnt=0. Any other byte loads response 0x3F '?' (1 byte) and goes to RESP.
  - ADDR: each rx_valid shifts the byte into addr[8*cnt +: 8] and increments cnt. On the 4th byte (cnt==3), go to DATA if write, else BUS; cnt wraps to 0.
  - DATA: same 4-byte collection into the write-data register, then BUS.
  - BUS: entered with cyc=stb=1 and adr/we/datwr/sel valid on the first BUS cycle. sel is all ones. adr passes through unmodified; the host supplies word-aligned addresses. Outputs are held until a cycle with wb_ack=1.
    - On ack: cyc=stb=we=0 next cycle.
    - Read: capture wb_datrd in the ack cycle and load a 4-byte response.
    - Write: load 1-byte response 0x4B 'K'.
    - Go to RESP.
  - RESP: tx_valid=1 with tx_data = current response byte (read data LSB first). On tx_valid&&tx_ready, advance to the next byte. After the last byte is accepted, tx_valid=0 next cycle and state=IDLE.
- Handshake rules:
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - Bus latency: cyc asserted the cycle after the last frame byte is received.
  - Minimum read transaction is one cycle of stb plus the ack cycle.
- rx_valid in BUS or RESP: byte discarded, rx_overrun pulses for 1 cycle, state unaffected.
- rx_valid and tx_ready in the same cycle in RESP: the tx advance proceeds and the rx byte is dropped as above.
- Reset mid-transaction: cyc/stb drop asynchronously; the partial frame is lost.
- No inter-byte timeout: a truncated frame stalls in ADDR/DATA until further bytes arrive.

Optional Feature:
- Macro: UART_WB_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches timeout_cycles-1 with no ack, the next cycle drops cyc/stb and loads response 0x45 'E' (1 byte) for both reads and writes.
  - An ack in that same cycle takes priority over the timeout.
- Disabled: no counter; BUS waits indefinitely for ack.

Decomposition:
- Shared package/header (include file alongside copperv_h.v):
  - command constants CMD_WRITE=0x57, CMD_READ=0x52
  - response constants RSP_OK=0x4B, RSP_BADCMD=0x3F, RSP_TIMEOUT=0x45
  - state encoding IDLE/ADDR/DATA/BUS/RESP
- One natural sub-module: uart_wb_master_resp, a response shifter. It loads 1 or 4 bytes plus a length and drives tx_valid/tx_data with the ready handshake.

Test Plan:
- Write: send 57 00 10 00 00 EF BE AD DE, slave acks after 3 cycles. Required: one cycle with adr=0x00001000, datwr=0xDEADBEEF, we=1, sel=F; tx emits 0x4B once.
- Read: send 52 00 10 00 00, slave returns 0xCAFEF00D. Required: we=0 during the cycle; tx emits 0D F0 FE CA in order.
- Backpressure: tx_ready low for 5 cycles per byte during the read response. Required: tx_data holds stable, no byte is duplicated or skipped.
- Bad command: send 0x41. Required: tx emits 0x3F, wb_cyc never asserted, state returns to IDLE.
- Overrun and reset: send a byte while in BUS. Required: rx_overrun pulses and the transaction completes normally. Then assert reset with cyc=1. Required: cyc/stb=0 immediately, busy=0.
- Timeout (macro on, timeout_cycles=16): read with no ack. Required: cyc drops after 16 cycles, tx emits 0x45.
